// File: rtl/laser_pkg.sv
// Shared parameters and types for the LASER cover checker: point format,
// evaluator states and counter widths.
package laser_pkg;

  localparam int NUM_PTS   = 40;
  localparam int COORD_W   = 4;
  localparam int RADIUS_SQ = 16;
  localparam int CNT_W     = 6;
  localparam int IDX_W     = 6;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PTS - 1);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    REPORT
  } evalState_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_t;

endpackage

// File: rtl/laser_in_circle.sv
// Combinational point-in-circle test: |px-cx|^2 + |py-cy|^2 <= RADIUS_SQ.
module laser_in_circle
  import laser_pkg::*;
(
  input  logic [COORD_W-1:0] px_i,
  input  logic [COORD_W-1:0] py_i,
  input  logic [COORD_W-1:0] cx_i,
  input  logic [COORD_W-1:0] cy_i,
  output logic               in_o
);

  localparam int SQ_W  = 2 * COORD_W;
  localparam int SUM_W = SQ_W + 1;

  logic [COORD_W-1:0] dx, dy;
  logic [SQ_W-1:0]    dxSq, dySq;
  logic [SUM_W-1:0]   sumSq;

  // Absolute differences keep everything unsigned; the 9-bit sum cannot overflow.
  always_comb begin
    dx    = (px_i >= cx_i) ? (px_i - cx_i) : (cx_i - px_i);
    dy    = (py_i >= cy_i) ? (py_i - cy_i) : (cy_i - py_i);
    dxSq  = {{COORD_W{1'b0}}, dx} * {{COORD_W{1'b0}}, dx};
    dySq  = {{COORD_W{1'b0}}, dy} * {{COORD_W{1'b0}}, dy};
    sumSq = {1'b0, dxSq} + {1'b0, dySq};
    in_o  = (sumSq <= SUM_W'(RADIUS_SQ));
  end

endmodule

// File: rtl/laser_cover_checker.sv
// Recounts two-circle coverage of each 40-point frame after the placer's DONE,
// using ping-pong point banks so the next frame loads during evaluation.
module laser_cover_checker
  import laser_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [COORD_W-1:0] c1x_i,
  input  logic [COORD_W-1:0] c1y_i,
  input  logic [COORD_W-1:0] c2x_i,
  input  logic [COORD_W-1:0] c2y_i,
  input  logic               done_i,
  output logic [CNT_W-1:0]   count_o,
  output logic [CNT_W-1:0]   c1_cnt_o,
  output logic [CNT_W-1:0]   c2_cnt_o,
  output logic               valid_o,
  output logic               busy_o,
  output logic               frame_err_o
);

  point_t           bank_q [2][NUM_PTS];
  logic             wBank_q, eBank_q, full_q;
  logic [IDX_W-1:0] loadCnt_q, idx_q;
  point_t           c1_q, c2_q;
  evalState_e       state_q, state_d;
  logic [CNT_W-1:0] c1Acc_q, c2Acc_q, uAcc_q;
  logic             doneAccept, doneReject, evalActive, reportActive, in1, in2;
  point_t           evalPt;

  assign doneAccept = done_i && full_q && (state_q == IDLE);
  assign doneReject = done_i && !doneAccept;
  assign evalPt     = bank_q[eBank_q][idx_q];

  // The loader is armed exactly when the write bank is not yet full.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wBank_q   <= 1'b0;
      loadCnt_q <= '0;
      full_q    <= 1'b0;
    end else if (doneAccept) begin
      wBank_q   <= ~wBank_q;
      loadCnt_q <= '0;
      full_q    <= 1'b0;
    end else if (!full_q) begin
      if (loadCnt_q == LAST_IDX) begin
        full_q    <= 1'b1;
        loadCnt_q <= '0;
      end else begin
        loadCnt_q <= loadCnt_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !full_q) begin
      bank_q[wBank_q][loadCnt_q] <= '{x: x_i, y: y_i};
    end
  end

  laser_in_circle inCircle1 (
    .px_i (evalPt.x),
    .py_i (evalPt.y),
    .cx_i (c1_q.x),
    .cy_i (c1_q.y),
    .in_o (in1)
  );

  laser_in_circle inCircle2 (
    .px_i (evalPt.x),
    .py_i (evalPt.y),
    .cx_i (c2_q.x),
    .cy_i (c2_q.y),
    .in_o (in2)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (doneAccept) state_d = EVAL;
      EVAL:    if (idx_q == LAST_IDX) state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state_q != IDLE);
    evalActive   = (state_q == EVAL);
    reportActive = (state_q == REPORT);
  end

  // Accumulators start each frame at zero: cleared on reset and after every report.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      eBank_q     <= 1'b0;
      c1_q        <= '0;
      c2_q        <= '0;
      idx_q       <= '0;
      c1Acc_q     <= '0;
      c2Acc_q     <= '0;
      uAcc_q      <= '0;
      count_o     <= '0;
      c1_cnt_o    <= '0;
      c2_cnt_o    <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      frame_err_o <= doneReject;
      if (doneAccept) begin
        c1_q    <= '{x: c1x_i, y: c1y_i};
        c2_q    <= '{x: c2x_i, y: c2y_i};
        eBank_q <= wBank_q;
        idx_q   <= '0;
      end
      if (evalActive) begin
        c1Acc_q <= c1Acc_q + CNT_W'(in1);
        c2Acc_q <= c2Acc_q + CNT_W'(in2);
        uAcc_q  <= uAcc_q + CNT_W'(in1 | in2);
        idx_q   <= idx_q + IDX_W'(1);
      end
      if (reportActive) begin
        count_o  <= uAcc_q;
        c1_cnt_o <= c1Acc_q;
        c2_cnt_o <= c2Acc_q;
        valid_o  <= 1'b1;
        c1Acc_q  <= '0;
        c2Acc_q  <= '0;
        uAcc_q   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_laser_cover_checker.sv
// Self-checking bench: directed frame table, hand-written protocol sequences and
// randomized traffic, all compared against a frame-level model of the checker.
module tb_laser_cover_checker;

  localparam int NPTS = 40;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } tbPt_t;

  typedef struct packed {
    logic [3:0]             c1x, c1y, c2x, c2y;
    logic [NPTS-1:0][7:0]   pts;
    logic [5:0]             expCount, expC1, expC2;
  } vec_t;

  logic       clk, rst, done;
  logic [3:0] x, y, c1x, c1y, c2x, c2y;
  logic [5:0] count, c1Cnt, c2Cnt;
  logic       valid, busy, frameErr;

  vec_t  vecs [3];
  int    checks = 0;
  int    errors = 0;
  int    edgeNo = 0;

  tbPt_t frameQ [$];
  int    busyUntil = -1;
  int    pendU, pend1, pend2;
  int    mCount, mC1, mC2, mValid, mBusy, mErr;

  laser_cover_checker dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .x_i         (x),
    .y_i         (y),
    .c1x_i       (c1x),
    .c1y_i       (c1y),
    .c2x_i       (c2x),
    .c2y_i       (c2y),
    .done_i      (done),
    .count_o     (count),
    .c1_cnt_o    (c1Cnt),
    .c2_cnt_o    (c2Cnt),
    .valid_o     (valid),
    .busy_o      (busy),
    .frame_err_o (frameErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit inRadius(tbPt_t p, logic [3:0] cx, logic [3:0] cy);
    int dx = int'(p.x) - int'(cx);
    int dy = int'(p.y) - int'(cy);
    return (dx * dx + dy * dy) <= 16;
  endfunction

  function automatic void countFrame(input tbPt_t f [$], input logic [3:0] ax, input logic [3:0] ay,
                                     input logic [3:0] bx, input logic [3:0] by,
                                     output int u, output int a, output int b);
    bit ia, ib;
    u = 0; a = 0; b = 0;
    foreach (f[i]) begin
      ia = inRadius(f[i], ax, ay);
      ib = inRadius(f[i], bx, by);
      a += int'(ia);
      b += int'(ib);
      u += int'(ia | ib);
    end
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame-level model: a frame is a queue of up to 40 points; an accepted frame
  // reports its counts 41 edges later and keeps the evaluator busy until then.
  task automatic modelEdge(input logic rIn, input logic [3:0] xIn, input logic [3:0] yIn, input logic dIn);
    if (rIn) begin
      frameQ.delete();
      busyUntil = -1;
      mCount = 0; mC1 = 0; mC2 = 0; mValid = 0; mBusy = 0; mErr = 0;
    end else begin
      mValid = 0;
      mErr   = 0;
      if (dIn && frameQ.size() == NPTS && edgeNo > busyUntil) begin
        countFrame(frameQ, c1x, c1y, c2x, c2y, pendU, pend1, pend2);
        frameQ.delete();
        busyUntil = edgeNo + NPTS + 1;
      end else begin
        if (dIn) mErr = 1;
        if (frameQ.size() < NPTS) frameQ.push_back('{x: xIn, y: yIn});
      end
      if (edgeNo == busyUntil) begin
        mValid = 1;
        mCount = pendU;
        mC1    = pend1;
        mC2    = pend2;
      end
      mBusy = (edgeNo < busyUntil) ? 1 : 0;
    end
  endtask

  task automatic checkOutput();
    checkVal($sformatf("count@%0d", edgeNo), int'(count), mCount);
    checkVal($sformatf("c1Cnt@%0d", edgeNo), int'(c1Cnt), mC1);
    checkVal($sformatf("c2Cnt@%0d", edgeNo), int'(c2Cnt), mC2);
    checkVal($sformatf("valid@%0d", edgeNo), (valid === 1'b1) ? 1 : 0, mValid);
    checkVal($sformatf("busy@%0d", edgeNo), (busy === 1'b1) ? 1 : 0, mBusy);
    checkVal($sformatf("frameErr@%0d", edgeNo), (frameErr === 1'b1) ? 1 : 0, mErr);
  endtask

  task automatic applyStimulus(input logic rIn, input logic [3:0] xIn, input logic [3:0] yIn, input logic dIn);
    rst  = rIn;
    x    = xIn;
    y    = yIn;
    done = dIn;
    @(posedge clk);
    edgeNo++;
    modelEdge(rIn, xIn, yIn, dIn);
    #1;
    checkOutput();
  endtask

  task automatic randStep(input logic dIn);
    applyStimulus(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), dIn);
  endtask

  task automatic waitValid(input int maxCycles, output int lat);
    lat = -1;
    for (int k = 1; k <= maxCycles; k++) begin
      randStep(1'b0);
      if (valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic setCentres(input logic [3:0] ax, input logic [3:0] ay, input logic [3:0] bx, input logic [3:0] by);
    c1x = ax; c1y = ay; c2x = bx; c2y = by;
  endtask

  initial begin
    int    lat;
    int    eU, e1, e2;
    tbPt_t qa [$];
    tbPt_t qb [$];
    tbPt_t p;

    rst = 1'b1; done = 1'b0; x = '0; y = '0;
    setCentres(4'd0, 4'd0, 4'd0, 4'd0);

    vecs[0] = '0; vecs[1] = '0; vecs[2] = '0;
    for (int i = 0; i < NPTS; i++) begin
      vecs[0].pts[i] = 8'h55;
      vecs[1].pts[i] = 8'hFF;
      vecs[2].pts[i] = (i < 10) ? 8'h76 : 8'hF0;
    end
    vecs[1].pts[0] = 8'hC8;
    vecs[1].pts[1] = 8'hBA;
    vecs[1].pts[2] = 8'hBB;
    vecs[1].pts[3] = 8'h8C;
    vecs[0].c1x = 4'd5; vecs[0].c1y = 4'd5;  vecs[0].c2x = 4'd12; vecs[0].c2y = 4'd12;
    vecs[0].expCount = 6'd40; vecs[0].expC1 = 6'd40; vecs[0].expC2 = 6'd0;
    vecs[1].c1x = 4'd8; vecs[1].c1y = 4'd8;  vecs[1].c2x = 4'd0;  vecs[1].c2y = 4'd0;
    vecs[1].expCount = 6'd3;  vecs[1].expC1 = 6'd3;  vecs[1].expC2 = 6'd0;
    vecs[2].c1x = 4'd6; vecs[2].c1y = 4'd6;  vecs[2].c2x = 4'd9;  vecs[2].c2y = 4'd6;
    vecs[2].expCount = 6'd10; vecs[2].expC1 = 6'd10; vecs[2].expC2 = 6'd10;

    $display("[TB] reset");
    applyStimulus(1'b1, 4'd0, 4'd0, 1'b0);
    applyStimulus(1'b1, 4'd0, 4'd0, 1'b0);
    checkVal("reset count", int'(count), 0);
    checkVal("reset busy", int'(busy), 0);

    $display("[TB] directed frame table");
    for (int v = 0; v < 3; v++) begin
      applyStimulus(1'b1, 4'd0, 4'd0, 1'b0);
      for (int i = 0; i < NPTS; i++)
        applyStimulus(1'b0, vecs[v].pts[i][7:4], vecs[v].pts[i][3:0], 1'b0);
      setCentres(vecs[v].c1x, vecs[v].c1y, vecs[v].c2x, vecs[v].c2y);
      applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
      checkVal($sformatf("vec%0d busy after DONE", v), int'(busy), 1);
      waitValid(60, lat);
      checkVal($sformatf("vec%0d latency", v), lat, 41);
      checkVal($sformatf("vec%0d COUNT", v), int'(count), int'(vecs[v].expCount));
      checkVal($sformatf("vec%0d C1_CNT", v), int'(c1Cnt), int'(vecs[v].expC1));
      checkVal($sformatf("vec%0d C2_CNT", v), int'(c2Cnt), int'(vecs[v].expC2));
    end

    $display("[TB] back-to-back frames");
    applyStimulus(1'b1, 4'd0, 4'd0, 1'b0);
    qa.delete(); qb.delete();
    for (int i = 0; i < NPTS; i++) begin
      p = '{x: 4'($urandom_range(0, 15)), y: 4'($urandom_range(0, 15))};
      qa.push_back(p);
      applyStimulus(1'b0, p.x, p.y, 1'b0);
    end
    setCentres(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    countFrame(qa, c1x, c1y, c2x, c2y, eU, e1, e2);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
    for (int i = 0; i < NPTS; i++) begin
      p = '{x: 4'($urandom_range(0, 15)), y: 4'($urandom_range(0, 15))};
      qb.push_back(p);
      applyStimulus(1'b0, p.x, p.y, 1'b0);
    end
    setCentres(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    randStep(1'b0);
    checkVal("frameA valid", int'(valid), 1);
    checkVal("frameA COUNT", int'(count), eU);
    checkVal("frameA C1_CNT", int'(c1Cnt), e1);
    checkVal("frameA C2_CNT", int'(c2Cnt), e2);
    countFrame(qb, c1x, c1y, c2x, c2y, eU, e1, e2);
    randStep(1'b1);
    checkVal("frameB accepted", int'(busy), 1);
    waitValid(60, lat);
    checkVal("frameB latency", lat, 41);
    checkVal("frameB COUNT", int'(count), eU);
    checkVal("frameB C1_CNT", int'(c1Cnt), e1);
    checkVal("frameB C2_CNT", int'(c2Cnt), e2);

    $display("[TB] early DONE");
    applyStimulus(1'b1, 4'd0, 4'd0, 1'b0);
    setCentres(4'd5, 4'd5, 4'd12, 4'd12);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 4'd5, 4'd5, 1'b0);
    applyStimulus(1'b0, 4'd5, 4'd5, 1'b1);
    checkVal("early DONE frameErr", int'(frameErr), 1);
    checkVal("early DONE busy", int'(busy), 0);
    applyStimulus(1'b0, 4'd5, 4'd5, 1'b0);
    checkVal("early DONE frameErr clears", int'(frameErr), 0);
    for (int i = 0; i < 18; i++) applyStimulus(1'b0, 4'd5, 4'd5, 1'b0);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
    checkVal("filled frame accepted", int'(busy), 1);
    waitValid(60, lat);
    checkVal("filled frame latency", lat, 41);
    checkVal("filled frame COUNT", int'(count), 40);

    $display("[TB] reset during evaluation");
    randStep(1'b1);
    checkVal("abort frame accepted", int'(busy), 1);
    for (int i = 0; i < 19; i++) randStep(1'b0);
    applyStimulus(1'b1, 4'd0, 4'd0, 1'b0);
    checkVal("mid reset COUNT", int'(count), 0);
    checkVal("mid reset C1_CNT", int'(c1Cnt), 0);
    checkVal("mid reset busy", int'(busy), 0);
    for (int i = 0; i < NPTS; i++)
      applyStimulus(1'b0, vecs[2].pts[i][7:4], vecs[2].pts[i][3:0], 1'b0);
    setCentres(vecs[2].c1x, vecs[2].c1y, vecs[2].c2x, vecs[2].c2y);
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b1);
    waitValid(60, lat);
    checkVal("post reset latency", lat, 41);
    checkVal("post reset COUNT", int'(count), 10);
    checkVal("post reset C2_CNT", int'(c2Cnt), 10);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0)
        setCentres(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      applyStimulus(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0,
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
